// File: rtl/fetch_ifid_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ifid_stage
// Description : Instruction fetch stage with IF/ID pipeline register.
//               The PC addresses instruction memory combinationally and the
//               returned instruction is latched one cycle later. The block
//               supports downstream stalls, branch redirects that flush the
//               register, and a HALT opcode that freezes fetch until the next
//               redirect or reset.
//               Optional feature: define FETCH_COUNT_EN to build a saturating
//               16-bit counter of valid instructions latched; without it
//               Fetch_Count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ifid_stage #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [7:0]  Branch_Target,
    input  logic [7:0]  Instr_In,
    output logic [7:0]  Instr_Addr,
    output logic [7:0]  Instr_IFID,
    output logic [7:0]  PC_IFID,
    output logic        Valid_IFID,
    output logic [2:0]  Rd_IFID,
    output logic        Halted,
    output logic [15:0] Fetch_Count
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0] state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] instr_ifid_q, instr_ifid_d;
    logic [7:0] pc_ifid_q, pc_ifid_d;
    logic       valid_ifid_q, valid_ifid_d;
    logic       w_fetch;
    logic       w_is_halt;

    // A real fetch happens only when running, not stalled and not redirected
    assign w_fetch   = !Branch_Taken && !Stall && (state_q == ST_RUN);
    assign w_is_halt = (Instr_In == HALT_OPCODE);

    // State register; reset dominates every other input
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a redirect always resumes running; HALT is only seen on a real fetch
    always_comb begin
        state_d = state_q;
        if (Branch_Taken) begin
            state_d = ST_RUN;
        end else if (w_fetch && w_is_halt) begin
            state_d = ST_HALTED;
        end
    end

    // FSM output
    always_comb begin
        Halted = (state_q == ST_HALTED);
    end

    // PC and IF/ID next values: redirect > stall > halted bubble > normal fetch
    always_comb begin
        pc_d         = pc_q;
        instr_ifid_d = instr_ifid_q;
        pc_ifid_d    = pc_ifid_q;
        valid_ifid_d = valid_ifid_q;
        if (Branch_Taken) begin
            pc_d         = Branch_Target;
            instr_ifid_d = 8'h00;
            valid_ifid_d = 1'b0;
        end else if (Stall) begin
            pc_d = pc_q;
        end else if (state_q == ST_HALTED) begin
            instr_ifid_d = 8'h00;
            valid_ifid_d = 1'b0;
        end else begin
            instr_ifid_d = Instr_In;
            pc_ifid_d    = pc_q;
            valid_ifid_d = 1'b1;
            // A HALT is latched but the PC parks on it
            pc_d         = w_is_halt ? pc_q : pc_q + 8'd1;
        end
    end

    // PC and IF/ID pipeline registers
    always_ff @(posedge clk) begin
        if (Reset) begin
            pc_q         <= RESET_PC;
            instr_ifid_q <= 8'h00;
            pc_ifid_q    <= 8'h00;
            valid_ifid_q <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            instr_ifid_q <= instr_ifid_d;
            pc_ifid_q    <= pc_ifid_d;
            valid_ifid_q <= valid_ifid_d;
        end
    end

    assign Instr_Addr = pc_q;
    assign Instr_IFID = instr_ifid_q;
    assign PC_IFID    = pc_ifid_q;
    assign Valid_IFID = valid_ifid_q;
    // Destination field goes straight to the register file, no extra stage
    assign Rd_IFID    = instr_ifid_q[5:3];

`ifdef FETCH_COUNT_EN
    logic [15:0] fetch_count_q, fetch_count_d;

    // Saturating count of instructions actually latched as valid
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (w_fetch && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    // Fetch counter register
    always_ff @(posedge clk) begin
        if (Reset) begin
            fetch_count_q <= 16'h0000;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign Fetch_Count = fetch_count_q;
`else
    assign Fetch_Count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_ifid_stage.md
FETCH_IFID_STAGE -- requirements
Module: fetch_ifid_stage

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-002 Parameter HALT_OPCODE, default 8'hFF, instruction encoding treated as HALT.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 Stall  input  1  hazard stall from downstream; holds PC and IF/ID register.
REQ-006 Branch_Taken  input  1  redirect request from EX stage.
REQ-007 Branch_Target  input  8  redirect PC value.
REQ-008 Instr_In  input  8  instruction from instruction memory, combinational from Instr_Addr.
REQ-009 Instr_Addr  output  8  current PC, driven directly from the PC register.
REQ-010 Instr_IFID  output  8  latched instruction.
REQ-011 PC_IFID  output  8  PC of the latched instruction.
REQ-012 Valid_IFID  output  1  latched instruction is real, not a bubble.
REQ-013 Rd_IFID  output  3  Instr_IFID[5:3], combinational; feeds register-file read address.
REQ-014 Halted  output  1  high while the FSM is in HALTED.
REQ-015 Fetch_Count  output  16  count of valid instructions latched (see Configuration).

Function
REQ-016 The FSM SHALL have two states: RUN and HALTED.
REQ-017 RUN, Stall=0, Branch_Taken=0: on the edge, Instr_IFID<=Instr_In, PC_IFID<=PC, Valid_IFID<=1, PC<=PC+1 modulo 256 (8'hFF wraps to 8'h00).
REQ-018 RUN, Instr_In==HALT_OPCODE, not stalled: the HALT SHALL be latched as a valid instruction, PC SHALL hold, and the next state SHALL be HALTED.
REQ-019 HALTED, no branch: PC SHALL hold; Instr_IFID<=8'h00 and Valid_IFID<=0 (bubble) every cycle, unless stalled.
REQ-020 Stall=1, Branch_Taken=0, any state: PC, Instr_IFID, PC_IFID, Valid_IFID and state SHALL hold.
REQ-021 Branch_Taken=1 SHALL take priority over Stall and HALT detection:
- PC<=Branch_Target
- Instr_IFID<=8'h00, Valid_IFID<=0 (flush)
- state<=RUN
REQ-022 Fetch latency SHALL be one cycle: the instruction at Instr_Addr=A appears on Instr_IFID the cycle after the capturing edge, with PC_IFID=A.
REQ-023 Rd_IFID SHALL track Instr_IFID with no additional register stage.

Reset
REQ-024 Reset=1 on an edge SHALL set:
- PC=RESET_PC
- Instr_IFID=8'h00, PC_IFID=8'h00, Valid_IFID=0
- state=RUN, Halted=0
- Fetch_Count=0
REQ-025 Reset SHALL override Branch_Taken, Stall and HALT, including when asserted mid-stall or while HALTED.
REQ-026 The first fetch SHALL occur on the first edge with Reset=0.

Configuration
REQ-027 With macro FETCH_COUNT_EN defined, Fetch_Count SHALL increment by 1 on every edge where Valid_IFID is loaded with 1, and SHALL saturate at 16'hFFFF.
REQ-028 Without FETCH_COUNT_EN, Fetch_Count SHALL be constant 16'h0000 and no counter register SHALL be built.

Verification
REQ-029 Reset, then 3 cycles with memory[0..2]=8'h11,8'h22,8'h33 -> Instr_IFID 11,22,33 with PC_IFID 0,1,2; Valid_IFID=1; Rd_IFID=2,4,6.
REQ-030 Stall=1 for 2 cycles at PC=5 -> Instr_Addr stays 5; IF/ID outputs unchanged; fetch resumes at 5.
REQ-031 Branch_Taken=1, Branch_Target=8'h40, Stall=1 -> next cycle Instr_Addr=8'h40, Valid_IFID=0, Instr_IFID=8'h00.
REQ-032 memory[3]=8'hFF -> HALT latched valid with PC_IFID=3; Halted=1; PC stays 3; subsequent cycles are bubbles; branch to 8'h10 -> Halted=0, fetch resumes at 8'h10.
REQ-033 PC at 8'hFF, not stalled -> next Instr_Addr=8'h00; Reset asserted while HALTED -> PC=RESET_PC, Halted=0.
REQ-034 With FETCH_COUNT_EN: 10 valid fetches, 2 stalls and 1 flush -> Fetch_Count=10. Without the macro: Fetch_Count=0 throughout.
